axi_line_bridge: RTL and testbench
==================================

Name: axi_line_bridge

Overview:
Parametrised AXI3 master bridging one cache/uncached requester to the SoC AXI interconnect.
- Cached requests move a full line as a single INCR burst of LINE_WORDS beats.
- Uncached requests move a single word with a byte strobe.
- Unlike the previous single-generation bridge, it drives real write data, waits for the B response, reports AXI errors and supports uncached single-beat mode.

Parameters:
LINE_WORDS, 8, words per cache line; power of two, 2..16; cached burst length.
AXI_ID, 0, constant ID driven on arid/awid/wid.

Ports:
aclk  in  1  clock.
aresetn  in  1  asynchronous active-low reset.
rd_req  in  1  read request; held until done.
wr_req  in  1  write request; held until done; wins over rd_req if both high.
uncached  in  1  1 = single-word access, 0 = full-line burst.
addr  in  32  byte address.
wr_strb  in  4  byte enables; uncached writes only.
wr_line  in  32*LINE_WORDS  write data; word i at bits [32i+31:32i].
rd_line  out  32*LINE_WORDS  read data, same packing; uncached read data lands in word 0.
done  out  1  one-cycle pulse: transaction finished, rd_line/err valid.
err  out  1  valid with done: any rresp/bresp != OKAY during the transaction.
arid, araddr, arlen, arsize, arburst, arvalid  out  4/32/8/3/2/1  AXI AR channel.
arready  in  1  AXI AR channel.
rdata, rresp, rlast, rvalid  in  32/2/1/1  AXI R channel.
rready  out  1  AXI R channel.
awid, awaddr, awlen, awsize, awburst, awvalid  out  4/32/8/3/2/1  AXI AW channel.
awready  in  1  AXI AW channel.
wid, wdata, wstrb, wlast, wvalid  out  4/32/4/1/1  AXI W channel.
wready  in  1  AXI W channel.
bresp, bvalid  in  2/1  AXI B channel.
bready  out  1  AXI B channel.
arlock/awlock (0), arcache/awcache (0), arprot/awprot (0)  out  2/4/3  constants; rid/bid inputs are ignored.

Behaviour:
- Reset (asynchronous, aresetn=0): state IDLE; all valid/ready outputs 0; done=0, err=0; rd_line=0; beat counter 0. Reset mid-burst abandons the transaction; no AXI valid is asserted on the first edge after release.
- States: IDLE, AR, R, AW, W, B, DONE.
- IDLE: if wr_req, go to AW; else if rd_req, go to AR. On that edge latch addr, uncached, wr_strb and wr_line, and clear the counter and sticky error. Requests are sampled only in IDLE.
- Address:
  - cached: addr with its low log2(LINE_WORDS)+2 bits cleared; len = LINE_WORDS-1; strobe = 4'b1111.
  - uncached: addr unchanged; len = 0; strobe = latched wr_strb.
  - Constants: size = 3'b010, burst = INCR (2'b01).
- AR: arvalid=1 until arready is sampled high, then go to R. araddr/arlen stay stable while arvalid=1.
- R: rready=1.
  - Each rvalid beat writes rdata into rd_line word [counter] and increments the counter.
  - The counter saturates at LINE_WORDS-1.
  - rresp != 0 sets the sticky error.
  - A beat with rlast=1 goes to DONE; the transaction ends on rlast, not on the count.
- AW: awvalid=1 until awready, then go to W. W is not issued before the AW handshake.
- W: wvalid=1; wdata = latched word [counter]; wlast = (counter == len).
  - Each wready beat increments the counter.
  - The wlast beat handshake goes to B.
  - wdata/wstrb/wlast stay stable while wvalid=1 and wready=0.
- B: bready=1 in B only. bvalid goes to DONE; bresp != 0 sets the sticky error.
- DONE: done=1 and err=sticky for exactly one cycle; rd_line holds until the next read completes. Next state is IDLE.
- The requester must drop rd_req/wr_req in the cycle after done; a request still high in IDLE starts a new transaction.
- Minimum latency: read = 1 (AR) + beats + 1 (DONE) cycles with zero-wait slaves; write = 1 (AW) + beats + 1 (B) + 1 (DONE).
- One outstanding transaction; no AXI ready/valid is combinationally dependent on the same-channel input.

Test Plan:
- Cached read, addr=0x1000_0014, LINE_WORDS=8, zero-wait slave returning 0xA0..0xA7 -> araddr=0x1000_0000, arlen=7, arsize=2; rd_line words 0..7 = 0xA0..0xA7; done 10 cycles after the IDLE accept; err=0.
- Cached write, wr_line word i = 0xB0+i, wready toggling every other cycle -> awlen=7; wdata sequence 0xB0..0xB7 with stable hold on stalls; wlast only on 0xB7; wstrb=F; done one cycle after bvalid.
- Uncached write, addr=0x1FAF_F002, wr_strb=4'b1100 -> awaddr=0x1FAF_F002, awlen=0, a single beat with wlast=1, wstrb=4'b1100.
- Read with rresp=SLVERR on beat 3, and write with bresp=SLVERR -> err=1 with done; a following clean read -> err=0.
- rd_req and wr_req high together -> AW issued, no AR.
- aresetn pulsed low mid-R (beat 4) -> all valids and done drop immediately; state IDLE; a new read afterwards completes correctly.
- LINE_WORDS=4 build, cached read at 0x0000_003C -> araddr=0x0000_0030, arlen=3.

Source files
------------

// File: rtl/axi_line_bridge.sv
// AXI3 master that moves one cache line (INCR burst) or one uncached word per
// request, with real write data, B-response wait and sticky error reporting.
module axi_line_bridge #(
  parameter int LINE_WORDS = 8,
  parameter int AXI_ID     = 0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     rd_req,
  input  logic                     wr_req,
  input  logic                     uncached,
  input  logic [31:0]              addr,
  input  logic [3:0]               wr_strb,
  input  logic [32*LINE_WORDS-1:0] wr_line,
  output logic [32*LINE_WORDS-1:0] rd_line,
  output logic                     done,
  output logic                     err,
  output logic [3:0]               arid,
  output logic [31:0]              araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  output logic [1:0]               arlock,
  output logic [3:0]               arcache,
  output logic [2:0]               arprot,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [3:0]               awid,
  output logic [31:0]              awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [1:0]               awlock,
  output logic [3:0]               awcache,
  output logic [2:0]               awprot,
  output logic [3:0]               wid,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready
);

  localparam int              CW        = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int              OFF_BITS  = $clog2(LINE_WORDS) + 2;
  localparam logic [31:0]     LINE_MASK = ~((32'd1 << OFF_BITS) - 32'd1);
  localparam logic [CW-1:0]   CNT_MAX   = CW'(LINE_WORDS - 1);
  localparam logic [7:0]      BURST_LEN = 8'(LINE_WORDS - 1);
  localparam logic [3:0]      ID        = 4'(AXI_ID);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW   = 3'd3;
  localparam logic [2:0] S_W    = 3'd4;
  localparam logic [2:0] S_B    = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]                       state, next_state;
  logic [CW-1:0]                    cnt;
  logic [31:0]                      addr_q;
  logic                             unc_q;
  logic [3:0]                       strb_q;
  logic                             err_q;
  logic [LINE_WORDS-1:0][31:0]      line_q;
  logic [LINE_WORDS-1:0][31:0]      rd_q;
  logic [31:0]                      bus_addr;
  logic [7:0]                       bus_len;
  logic                             accept;

  assign accept   = (state == S_IDLE) && (wr_req || rd_req);
  assign bus_addr = unc_q ? addr_q : (addr_q & LINE_MASK);
  assign bus_len  = unc_q ? 8'd0 : BURST_LEN;

  always_comb begin
    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    next_state = state;
    case (state)
      S_IDLE: begin
        if (wr_req)      next_state = S_AW;
        else if (rd_req) next_state = S_AR;
      end
      S_AR:    if (arready)          next_state = S_R;
      S_R:     if (rvalid && rlast)  next_state = S_DONE;
      S_AW:    if (awready)          next_state = S_W;
      S_W:     if (wready && wlast)  next_state = S_B;
      S_B:     if (bvalid)           next_state = S_DONE;
      S_DONE:                        next_state = S_IDLE;
      default:                       next_state = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      addr_q <= '0;
      unc_q  <= 1'b0;
      strb_q <= '0;
      err_q  <= 1'b0;
      rd_q   <= '0;
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: if (accept) begin
          addr_q <= addr;
          unc_q  <= uncached;
          strb_q <= wr_strb;
          cnt    <= '0;
          err_q  <= 1'b0;
        end
        S_R: if (rvalid) begin
          rd_q[cnt] <= rdata;
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          if (rresp != 2'b00) err_q <= 1'b1;
        end
        S_W: if (wready && cnt != CNT_MAX) cnt <= cnt + 1'b1;
        S_B: if (bvalid && bresp != 2'b00) err_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the write-data copy is only read after being loaded, so it needs no reset.
  always_ff @(posedge aclk) begin
    if (accept) line_q <= wr_line;
  end

  assign rd_line = rd_q;
  assign done    = (state == S_DONE);
  assign err     = (state == S_DONE) && err_q;

  assign arid    = ID;
  assign araddr  = bus_addr;
  assign arlen   = bus_len;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = (state == S_AR);
  assign rready  = (state == S_R);

  assign awid    = ID;
  assign awaddr  = bus_addr;
  assign awlen   = bus_len;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = (state == S_AW);

  // Write beats are indexed by the beat counter; uncached bursts are one beat long.
  assign wid     = ID;
  assign wdata   = line_q[cnt];
  assign wstrb   = unc_q ? strb_q : 4'b1111;
  assign wlast   = (8'(cnt) == bus_len);
  assign wvalid  = (state == S_W);
  assign bready  = (state == S_B);

endmodule

// File: tb/tb_axi_line_bridge.sv
// Scoreboard bench for axi_line_bridge: an AXI slave model drives responses while
// expected AR/AW/W/done values queued at request time are popped as the DUT emits them.
module tb_axi_line_bridge;
  localparam int LW = 8;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } addr_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } wbeat_t;
  typedef struct packed { logic err; logic [LW*32-1:0] line; } resp_t;

  logic aclk = 1'b0;
  logic aresetn;
  logic rd_req, wr_req, uncached;
  logic [31:0] addr;
  logic [3:0]  wr_strb;
  logic [LW*32-1:0] wr_line, rd_line;
  logic done, err;
  logic [3:0] arid, awid, wid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0] arcache, awcache, wstrb;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic wlast, wvalid, wready, bvalid, bready;

  // Second instance built with a 4-word line
  logic q_rd_req, q_rvalid, q_rlast, q_done, q_err, q_arvalid, q_rready;
  logic [31:0] q_addr, q_rdata, q_araddr, q_awaddr, q_wdata;
  logic [127:0] q_rd_line;
  logic [7:0] q_arlen, q_awlen;
  logic [3:0] q_arid, q_awid, q_wid, q_arcache, q_awcache, q_wstrb;
  logic [2:0] q_arsize, q_awsize, q_arprot, q_awprot;
  logic [1:0] q_arburst, q_awburst, q_arlock, q_awlock;
  logic q_awvalid, q_wlast, q_wvalid, q_bready;

  int checks = 0;
  int errors = 0;

  addr_t  ar_q[$];
  addr_t  aw_q[$];
  wbeat_t w_q[$];
  resp_t  d_q[$];

  logic [31:0]      r_data [LW];
  int               r_err_beat = -1;
  bit               b_err = 1'b0;
  bit               w_stall = 1'b0;
  int               abort_beat = -1;
  bit               aborted;
  logic [LW*32-1:0] model_line = '0;

  always #5 aclk = ~aclk;

  axi_line_bridge #(.LINE_WORDS(LW), .AXI_ID(3)) dut (
    .aclk(aclk), .aresetn(aresetn), .rd_req(rd_req), .wr_req(wr_req), .uncached(uncached),
    .addr(addr), .wr_strb(wr_strb), .wr_line(wr_line), .rd_line(rd_line), .done(done), .err(err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  axi_line_bridge #(.LINE_WORDS(4), .AXI_ID(0)) dut4 (
    .aclk(aclk), .aresetn(aresetn), .rd_req(q_rd_req), .wr_req(1'b0), .uncached(1'b0),
    .addr(q_addr), .wr_strb(4'h0), .wr_line(128'h0), .rd_line(q_rd_line), .done(q_done), .err(q_err),
    .arid(q_arid), .araddr(q_araddr), .arlen(q_arlen), .arsize(q_arsize), .arburst(q_arburst),
    .arvalid(q_arvalid), .arready(1'b1), .arlock(q_arlock), .arcache(q_arcache), .arprot(q_arprot),
    .rdata(q_rdata), .rresp(2'b00), .rlast(q_rlast), .rvalid(q_rvalid), .rready(q_rready),
    .awid(q_awid), .awaddr(q_awaddr), .awlen(q_awlen), .awsize(q_awsize), .awburst(q_awburst),
    .awvalid(q_awvalid), .awready(1'b0), .awlock(q_awlock), .awcache(q_awcache), .awprot(q_awprot),
    .wid(q_wid), .wdata(q_wdata), .wstrb(q_wstrb), .wlast(q_wlast), .wvalid(q_wvalid), .wready(1'b0),
    .bresp(2'b00), .bvalid(1'b0), .bready(q_bready)
  );

  // Issue one request, queue its expected bus activity, then act as the slave until done.
  // exp_lat counts cycles from the accept edge, the AR/AW cycle being 1 and the done cycle last.
  task automatic run_txn(input bit wr, input bit rd, input bit unc, input logic [31:0] a,
                         input logic [3:0] s, input logic [LW*32-1:0] line, input int exp_lat);
    logic [7:0] len;
    addr_t      ea, ga;
    wbeat_t     ew;
    resp_t      er;
    bit         exp_err, fin, aw_seen, b_sent;
    int         beat, b_cyc, cyc;
    len = unc ? 8'd0 : 8'(LW - 1);
    ea.addr = unc ? a : {a[31:5], 5'b0};
    ea.len  = len;
    if (wr) begin
      aw_q.push_back(ea);
      for (int i = 0; i <= int'(len); i++) begin
        ew.data = line[i*32 +: 32];
        ew.strb = unc ? s : 4'hF;
        ew.last = (i == int'(len));
        w_q.push_back(ew);
      end
      exp_err = b_err;
    end else begin
      ar_q.push_back(ea);
      for (int i = 0; i <= int'(len); i++) model_line[i*32 +: 32] = r_data[i];
      exp_err = (r_err_beat >= 0) && (r_err_beat <= int'(len));
    end
    er.err  = exp_err;
    er.line = model_line;
    d_q.push_back(er);

    @(negedge aclk);
    wr_req = wr; rd_req = rd; uncached = unc; addr = a; wr_strb = s; wr_line = line;
    beat = 0; b_cyc = -100; fin = 0; aw_seen = 0; b_sent = 0; aborted = 0; cyc = 0;
    while (cyc < 200 && !fin) begin
      @(negedge aclk);
      cyc++;
      rvalid = 0; rlast = 0; rresp = 2'b00; bvalid = 0; bresp = 2'b00;
      wready = w_stall ? cyc[0] : 1'b1;
      if (arvalid) begin
        checks++;
        if (ar_q.size() == 0) begin
          errors++; $display("FAIL unexpected_ar: got araddr %h, required no AR", araddr);
        end else begin
          ga = ar_q.pop_front();
          if ({araddr, arlen, arsize, arburst, arid} !== {ga.addr, ga.len, 3'b010, 2'b01, 4'd3}) begin
            errors++;
            $display("FAIL ar_fields: got addr %h len %0d size %0d burst %0d id %0d, required addr %h len %0d size 2 burst 1 id 3",
                     araddr, arlen, arsize, arburst, arid, ga.addr, ga.len);
          end
        end
      end
      if (awvalid) begin
        checks++;
        aw_seen = 1;
        if (aw_q.size() == 0) begin
          errors++; $display("FAIL unexpected_aw: got awaddr %h, required no AW", awaddr);
        end else begin
          ga = aw_q.pop_front();
          if ({awaddr, awlen, awsize, awburst, awid} !== {ga.addr, ga.len, 3'b010, 2'b01, 4'd3}) begin
            errors++;
            $display("FAIL aw_fields: got addr %h len %0d size %0d burst %0d id %0d, required addr %h len %0d size 2 burst 1 id 3",
                     awaddr, awlen, awsize, awburst, awid, ga.addr, ga.len);
          end
        end
      end
      if (wvalid) begin
        checks++;
        if (!aw_seen || w_q.size() == 0) begin
          errors++; $display("FAIL w_order: got wvalid with wdata %h, required no W beat now", wdata);
        end else begin
          ew = w_q[0];
          if ({wdata, wstrb, wlast} !== {ew.data, ew.strb, ew.last}) begin
            errors++;
            $display("FAIL w_beat: got data %h strb %h last %b, required data %h strb %h last %b",
                     wdata, wstrb, wlast, ew.data, ew.strb, ew.last);
          end
          if (wready) void'(w_q.pop_front());
        end
      end
      if (rready && abort_beat >= 0 && beat == abort_beat) begin
        #1 aresetn = 1'b0;
        #1;
        rd_req = 0; wr_req = 0; fin = 1; aborted = 1;
      end else begin
        if (rready && beat <= int'(len)) begin
          rvalid = 1'b1;
          rdata  = r_data[beat];
          rlast  = (beat == int'(len));
          rresp  = (beat == r_err_beat) ? 2'b10 : 2'b00;
          beat++;
        end
        if (bready && !b_sent) begin
          bvalid = 1'b1; bresp = b_err ? 2'b10 : 2'b00; b_sent = 1; b_cyc = cyc;
        end
        if (done) begin
          fin = 1; rd_req = 0; wr_req = 0;
          er = d_q.pop_front();
          checks++;
          if (err !== er.err) begin
            errors++; $display("FAIL done_err: got %b, required %b", err, er.err);
          end
          checks++;
          if (rd_line !== er.line) begin
            errors++; $display("FAIL rd_line: got %h, required %h", rd_line, er.line);
          end
          if (exp_lat > 0) begin
            checks++;
            if (cyc != exp_lat) begin
              errors++; $display("FAIL latency: got %0d cycles, required %0d", cyc, exp_lat);
            end
          end
          if (wr) begin
            checks++;
            if (cyc != b_cyc + 1) begin
              errors++; $display("FAIL done_after_b: got done at cycle %0d, required %0d", cyc, b_cyc + 1);
            end
          end
        end
      end
    end
    checks++;
    if (!fin) begin
      errors++; $display("FAIL timeout: got no done in 200 cycles, required done");
      rd_req = 0; wr_req = 0;
    end
    if (!aborted) begin
      @(negedge aclk);
      checks++;
      if (done !== 1'b0 || ar_q.size() + aw_q.size() + w_q.size() + d_q.size() != 0) begin
        errors++;
        $display("FAIL drain: got done %b pending %0d, required done 0 pending 0",
                 done, ar_q.size() + aw_q.size() + w_q.size() + d_q.size());
      end
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0; rd_req = 0; wr_req = 0; uncached = 0; addr = '0; wr_strb = '0; wr_line = '0;
    arready = 1; awready = 1; wready = 0; rvalid = 0; rlast = 0; rdata = '0; rresp = '0;
    bvalid = 0; bresp = '0; q_rd_req = 0; q_addr = '0; q_rvalid = 0; q_rlast = 0; q_rdata = '0;
    #12;
    checks++;
    if ({arvalid, awvalid, wvalid, rready, bready, done, err} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, required 0000000",
                         {arvalid, awvalid, wvalid, rready, bready, done, err});
    end
    checks++;
    if (rd_line !== '0) begin
      errors++; $display("FAIL reset_rd_line: got %h, required 0", rd_line);
    end
    @(negedge aclk) aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if ({arvalid, awvalid, done} !== 3'b0) begin
      errors++; $display("FAIL post_reset_idle: got %b, required 000", {arvalid, awvalid, done});
    end
  endtask

  task automatic test_cached_read();
    for (int i = 0; i < LW; i++) r_data[i] = 32'hA0 + i;
    run_txn(1'b0, 1'b1, 1'b0, 32'h1000_0014, 4'h0, '0, 10);
  endtask

  task automatic test_cached_write();
    logic [LW*32-1:0] line;
    for (int i = 0; i < LW; i++) line[i*32 +: 32] = 32'hB0 + i;
    w_stall = 1;
    run_txn(1'b1, 1'b0, 1'b0, 32'h2000_0044, 4'h0, line, 0);
    w_stall = 0;
    run_txn(1'b1, 1'b0, 1'b0, 32'h2000_0080, 4'h0, ~line, 11);
  endtask

  task automatic test_uncached_write();
    logic [LW*32-1:0] line;
    for (int i = 0; i < LW; i++) line[i*32 +: 32] = 32'h5500_0000 + i;
    run_txn(1'b1, 1'b0, 1'b1, 32'h1FAF_F002, 4'b1100, line, 4);
  endtask

  task automatic test_errors();
    for (int i = 0; i < LW; i++) r_data[i] = 32'hC0 + i;
    r_err_beat = 3;
    run_txn(1'b0, 1'b1, 1'b0, 32'h3000_0000, 4'h0, '0, 10);
    r_err_beat = -1;
    b_err = 1;
    run_txn(1'b1, 1'b0, 1'b0, 32'h3000_0100, 4'h0, {LW{32'h1234_5678}}, 0);
    b_err = 0;
    for (int i = 0; i < LW; i++) r_data[i] = 32'hE0 + i;
    run_txn(1'b0, 1'b1, 1'b0, 32'h3000_0200, 4'h0, '0, 10);
  endtask

  task automatic test_both_req();
    run_txn(1'b1, 1'b1, 1'b0, 32'h4000_0020, 4'h0, {LW{32'hCAFE_0001}}, 0);
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < LW; i++) r_data[i] = 32'h70 + i;
    abort_beat = 4;
    run_txn(1'b0, 1'b1, 1'b0, 32'h5000_0000, 4'h0, '0, 0);
    abort_beat = -1;
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, done, err} !== 7'b0 || rd_line !== '0) begin
      errors++; $display("FAIL mid_reset: got ctrl %b rd_line %h, required 0 and 0",
                         {arvalid, rready, awvalid, wvalid, bready, done, err}, rd_line);
    end
    ar_q.delete(); d_q.delete();
    model_line = '0;
    @(negedge aclk) aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if ({arvalid, awvalid, rready} !== 3'b0) begin
      errors++; $display("FAIL after_release: got %b, required 000", {arvalid, awvalid, rready});
    end
    for (int i = 0; i < LW; i++) r_data[i] = 32'h90 + i;
    run_txn(1'b0, 1'b1, 1'b0, 32'h5000_0040, 4'h0, '0, 10);
  endtask

  task automatic test_line4();
    logic [127:0] exp_line;
    int beat;
    bit fin, ar_seen;
    for (int i = 0; i < 4; i++) exp_line[i*32 +: 32] = 32'hD0 + i;
    beat = 0; fin = 0; ar_seen = 0;
    @(negedge aclk);
    q_rd_req = 1; q_addr = 32'h0000_003C;
    for (int cyc = 1; cyc <= 50 && !fin; cyc++) begin
      @(negedge aclk);
      q_rvalid = 0; q_rlast = 0;
      if (q_arvalid) begin
        ar_seen = 1;
        checks++;
        if ({q_araddr, q_arlen} !== {32'h0000_0030, 8'd3}) begin
          errors++; $display("FAIL line4_ar: got addr %h len %0d, required addr 00000030 len 3", q_araddr, q_arlen);
        end
      end
      if (q_rready && beat < 4) begin
        q_rvalid = 1; q_rdata = 32'hD0 + beat; q_rlast = (beat == 3); beat++;
      end
      if (q_done) begin
        fin = 1; q_rd_req = 0;
        checks++;
        if (q_rd_line !== exp_line || q_err !== 1'b0) begin
          errors++; $display("FAIL line4_data: got %h err %b, required %h err 0", q_rd_line, q_err, exp_line);
        end
      end
    end
    checks++;
    if (!fin || !ar_seen) begin
      errors++; $display("FAIL line4_done: got done %b ar %b, required 1 1", fin, ar_seen);
    end
  endtask

  initial begin
    test_reset();
    test_cached_read();
    test_cached_write();
    test_uncached_write();
    test_errors();
    test_both_req();
    test_reset_mid_burst();
    test_line4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
